// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the program/data RAM arbiter: default widths,
// FSM state encoding and master indices.
package ram_port_arbiter_pkg;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  localparam logic M_CORE = 1'b0;
  localparam logic M_HOST = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both master request/response ports plus the RAM command port.
// The arbiter uses the slave view; the masters and RAM sit on the master view.
interface ram_port_arbiter_if
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic                  m0_valid;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [DATA_W/8-1:0]   m0_wstrb;
  logic                  m0_ready;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_valid;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [DATA_W/8-1:0]   m1_wstrb;
  logic                  m1_ready;
  logic [DATA_W-1:0]     m1_rdata;
  logic                  m1_lock;

  logic [ADDR_W-1:0]     ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W/8-1:0]   ram_wstrb;
  logic                  ram_en;
  logic [DATA_W-1:0]     ram_rdata;

  modport slave (
    input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
    output m0_ready, m0_rdata,
    input  m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    output m1_ready, m1_rdata,
    output ram_addr, ram_wdata, ram_wstrb, ram_en,
    input  ram_rdata
  );

  modport master (
    output m0_valid, m0_addr, m0_wdata, m0_wstrb,
    input  m0_ready, m0_rdata,
    output m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_lock,
    input  m1_ready, m1_rdata,
    input  ram_addr, ram_wdata, ram_wstrb, ram_en,
    output ram_rdata
  );

endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the core (m0) and
// the host loader (m1); one transfer per two cycles, with an m1 lock.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  ram_port_arbiter_if.slave bus
);

  state_t state_q, state_d;
  logic   gnt_q;
  logic   last_q;
  logic   lock_q;
  logic   m0_elig;
  logic   m1_elig;
  logic   have_winner;
  logic   winner;

  // While the host holds the lock the core is simply not eligible; ties go
  // to whichever master did not win last time. Nothing issues during reset.
  always_comb begin
    m0_elig     = bus.m0_valid && !lock_q;
    m1_elig     = bus.m1_valid;
    have_winner = (state_q == ST_IDLE) && resetn && (m0_elig || m1_elig);
    if (m0_elig && m1_elig) begin
      winner = ~last_q;
    end else begin
      winner = m1_elig ? M_HOST : M_CORE;
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.ram_en    = 1'b0;
    bus.ram_wstrb = '0;
    bus.ram_addr  = bus.m0_addr;
    bus.ram_wdata = bus.m0_wdata;
    bus.m0_ready  = 1'b0;
    bus.m1_ready  = 1'b0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (have_winner) begin
          bus.ram_en = 1'b1;
          state_d    = ST_ACK;
          if (winner == M_HOST) begin
            bus.ram_addr  = bus.m1_addr;
            bus.ram_wdata = bus.m1_wdata;
            bus.ram_wstrb = bus.m1_wstrb;
          end else begin
            bus.ram_wstrb = bus.m0_wstrb;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
        if (gnt_q == M_HOST) begin
          bus.m1_ready = 1'b1;
          bus.m1_rdata = bus.ram_rdata;
        end else begin
          bus.m0_ready = 1'b1;
          bus.m0_rdata = bus.ram_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Lock is only re-evaluated between transfers: it is taken when the host
  // wins with m1_lock set and released in any idle cycle where it is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      gnt_q   <= M_CORE;
      last_q  <= M_HOST;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (have_winner) begin
        gnt_q  <= winner;
        last_q <= winner;
      end
      if (state_q == ST_IDLE) begin
        if (!bus.m1_lock) begin
          lock_q <= 1'b0;
        end else if (have_winner && (winner == M_HOST)) begin
          lock_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: directed vector table, corner-case
// sequences and random traffic against a transaction-level reference model.
module tb_ram_port_arbiter;
  import ram_port_arbiter_pkg::*;

  localparam int AW = DEF_ADDR_W;
  localparam int DW = DEF_DATA_W;
  localparam int SW = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  ram_port_arbiter_if bus ();

  ram_port_arbiter dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Byte-enabled 2k x 32 RAM with a one-cycle registered read.
  logic [DW-1:0] ram_mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (bus.ram_en === 1'b1) begin
      bus.ram_rdata <= ram_mem[bus.ram_addr];
      for (int b = 0; b < SW; b++) begin
        if (bus.ram_wstrb[b]) ram_mem[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
      end
    end
  end

  // Reference model: a transfer is won in a free cycle and answered in the
  // next one; the model keeps its own copy of memory contents.
  int            mdl_pending;
  logic          mdl_last;
  logic          mdl_lock;
  logic          mdl_is_read;
  logic [DW-1:0] mdl_rdata;
  logic [DW-1:0] mdl_mem [0:DEPTH-1];
  logic          obs_m0_ready;
  logic          obs_m1_ready;

  typedef struct {
    logic          m0_valid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic [SW-1:0] m0_wstrb;
    logic          m1_valid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [SW-1:0] m1_wstrb;
    logic          m1_lock;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic          exp_m0_ready;
    logic          exp_m1_ready;
    logic          chk_rdata;
    logic [DW-1:0] exp_m0_rdata;
    logic [DW-1:0] exp_m1_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.m0_valid = v.m0_valid;
    bus.m0_addr  = v.m0_addr;
    bus.m0_wdata = v.m0_wdata;
    bus.m0_wstrb = v.m0_wstrb;
    bus.m1_valid = v.m1_valid;
    bus.m1_addr  = v.m1_addr;
    bus.m1_wdata = v.m1_wdata;
    bus.m1_wstrb = v.m1_wstrb;
    bus.m1_lock  = v.m1_lock;
  endtask

  task automatic clear_inputs();
    bus.m0_valid = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
    bus.m1_valid = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
    bus.m1_lock  = 1'b0;
  endtask

  task automatic model_reset();
    mdl_pending = -1;
    mdl_last    = 1'b1;
    mdl_lock    = 1'b0;
    mdl_is_read = 1'b0;
    mdl_rdata   = '0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = ram_mem[i];
  endtask

  function automatic int model_winner();
    logic e0, e1;
    e0 = bus.m0_valid && !mdl_lock;
    e1 = bus.m1_valid;
    if (e0 && e1) return mdl_last ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // Called at a falling edge with inputs already driven; checks this cycle,
  // advances the model at the rising edge and returns at the next falling edge.
  task automatic step();
    int            w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [SW-1:0] strb;
    logic [DW-1:0] mask;
    #1;
    obs_m0_ready = bus.m0_ready;
    obs_m1_ready = bus.m1_ready;
    if (mdl_pending >= 0) begin
      check_output("ack_ram_en", bus.ram_en, 1'b0);
      check_output("ack_ram_wstrb", bus.ram_wstrb, '0);
      check_output("ack_m0_ready", bus.m0_ready, mdl_pending == 0);
      check_output("ack_m1_ready", bus.m1_ready, mdl_pending == 1);
      if (mdl_pending == 0) begin
        if (mdl_is_read) check_output("ack_m0_rdata", bus.m0_rdata, mdl_rdata);
        check_output("ack_m1_rdata_zero", bus.m1_rdata, '0);
      end else begin
        if (mdl_is_read) check_output("ack_m1_rdata", bus.m1_rdata, mdl_rdata);
        check_output("ack_m0_rdata_zero", bus.m0_rdata, '0);
      end
    end else begin
      w = model_winner();
      check_output("idle_ram_en", bus.ram_en, w >= 0);
      check_output("idle_m0_ready", bus.m0_ready, 1'b0);
      check_output("idle_m1_ready", bus.m1_ready, 1'b0);
      check_output("idle_m0_rdata", bus.m0_rdata, '0);
      check_output("idle_m1_rdata", bus.m1_rdata, '0);
      if (w == 0) begin
        check_output("issue_addr_m0", bus.ram_addr, bus.m0_addr);
        check_output("issue_wdata_m0", bus.ram_wdata, bus.m0_wdata);
        check_output("issue_wstrb_m0", bus.ram_wstrb, bus.m0_wstrb);
      end else if (w == 1) begin
        check_output("issue_addr_m1", bus.ram_addr, bus.m1_addr);
        check_output("issue_wdata_m1", bus.ram_wdata, bus.m1_wdata);
        check_output("issue_wstrb_m1", bus.ram_wstrb, bus.m1_wstrb);
      end else begin
        check_output("idle_ram_wstrb", bus.ram_wstrb, '0);
      end
    end
    @(posedge clk);
    if (mdl_pending >= 0) begin
      mdl_pending = -1;
    end else begin
      w = model_winner();
      if (!bus.m1_lock) mdl_lock = 1'b0;
      else if (w == 1) mdl_lock = 1'b1;
      if (w >= 0) begin
        addr = (w == 1) ? bus.m1_addr  : bus.m0_addr;
        wd   = (w == 1) ? bus.m1_wdata : bus.m0_wdata;
        strb = (w == 1) ? bus.m1_wstrb : bus.m0_wstrb;
        mask = '0;
        for (int b = 0; b < SW; b++) if (strb[b]) mask[8*b +: 8] = 8'hFF;
        mdl_is_read   = (strb == '0);
        mdl_rdata     = mdl_mem[addr];
        mdl_mem[addr] = (mdl_mem[addr] & ~mask) | (wd & mask);
        mdl_last      = (w == 1);
        mdl_pending   = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int m0_cnt, m1_cnt, consec, prev, first, found, m0_seen;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = DW'(i) * 32'h0101_0101;
    ram_mem[11'h005] = 32'hDEAD_BEEF;
    ram_mem[11'h7FF] = 32'hAAAA_0000;

    // Outputs must stay quiet while reset is held, even with a pending write.
    bus.m0_valid = 1'b1; bus.m0_wstrb = 4'hF;
    #1;
    check_output("rst_ram_en", bus.ram_en, 1'b0);
    check_output("rst_ram_wstrb", bus.ram_wstrb, '0);
    check_output("rst_m0_ready", bus.m0_ready, 1'b0);
    check_output("rst_m1_ready", bus.m1_ready, 1'b0);
    clear_inputs();
    @(negedge clk);
    resetn = 1'b1;

    vecs[0] = '{1'b1, 11'h005, 32'h0, 4'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0,
                1'b1, 11'h005, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 11'h005, 32'h0, 4'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0,
                1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b0, 11'h000, 32'h0, 4'h0, 1'b1, 11'h7FF, 32'h1234_5678, 4'h3, 1'b0,
                1'b1, 11'h7FF, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[3] = '{1'b0, 11'h000, 32'h0, 4'h0, 1'b1, 11'h7FF, 32'h1234_5678, 4'h3, 1'b0,
                1'b0, 11'h000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{1'b1, 11'h7FF, 32'h0, 4'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0,
                1'b1, 11'h7FF, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    vecs[5] = '{1'b1, 11'h7FF, 32'h0, 4'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0,
                1'b0, 11'h000, 1'b1, 1'b0, 1'b1, 32'hAAAA_5678, 32'h0};
    vecs[6] = '{1'b0, 11'h000, 32'h0, 4'h0, 1'b0, 11'h0, 32'h0, 4'h0, 1'b0,
                1'b0, 11'h000, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("vec%0d_ram_en", i), bus.ram_en, vecs[i].exp_en);
      if (vecs[i].exp_en) check_output($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vecs[i].exp_addr);
      check_output($sformatf("vec%0d_m0_ready", i), bus.m0_ready, vecs[i].exp_m0_ready);
      check_output($sformatf("vec%0d_m1_ready", i), bus.m1_ready, vecs[i].exp_m1_ready);
      if (vecs[i].chk_rdata) begin
        check_output($sformatf("vec%0d_m0_rdata", i), bus.m0_rdata, vecs[i].exp_m0_rdata);
        check_output($sformatf("vec%0d_m1_rdata", i), bus.m1_rdata, vecs[i].exp_m1_rdata);
      end
      @(negedge clk);
    end

    // Both masters requesting continuously: grants must alternate from m0.
    do_reset();
    bus.m0_valid = 1'b1; bus.m0_addr = 11'h001;
    bus.m1_valid = 1'b1; bus.m1_addr = 11'h002;
    m0_cnt = 0; m1_cnt = 0; consec = 0; prev = -1; first = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      if (obs_m0_ready) begin
        m0_cnt++; if (prev == 0) consec++; prev = 0; if (first < 0) first = 0;
      end
      if (obs_m1_ready) begin
        m1_cnt++; if (prev == 1) consec++; prev = 1; if (first < 0) first = 1;
      end
    end
    check_output("fair_first_is_m0", first, 0);
    check_output("fair_m0_count", m0_cnt, 4);
    check_output("fair_m1_count", m1_cnt, 4);
    check_output("fair_consecutive", consec, 0);

    // Host lock: core starves for three host transfers, then wins promptly.
    do_reset();
    bus.m1_valid = 1'b1; bus.m1_addr = 11'h003; bus.m1_lock = 1'b1;
    m0_seen = 0; m1_cnt = 0;
    step();
    bus.m0_valid = 1'b1; bus.m0_addr = 11'h004;
    for (int i = 0; i < 5; i++) begin
      step();
      if (obs_m0_ready) m0_seen++;
      if (obs_m1_ready) m1_cnt++;
    end
    check_output("lock_m0_starved", m0_seen, 0);
    check_output("lock_m1_transfers", m1_cnt, 3);
    bus.m1_valid = 1'b0; bus.m1_lock = 1'b0;
    found = 0;
    for (int i = 0; i < 3 && found == 0; i++) begin
      step();
      if (obs_m0_ready) found = 1;
    end
    check_output("unlock_m0_granted", found, 1);

    // Reset during an acknowledge cycle, with the lock request still high.
    do_reset();
    bus.m1_valid = 1'b1; bus.m1_addr = 11'h006; bus.m1_lock = 1'b1;
    step();
    bus.m0_valid = 1'b1; bus.m0_addr = 11'h007;
    #1;
    check_output("pre_rst_m1_ready", bus.m1_ready, 1'b1);
    resetn = 1'b0;
    #1;
    check_output("mid_rst_m1_ready", bus.m1_ready, 1'b0);
    check_output("mid_rst_m0_ready", bus.m0_ready, 1'b0);
    check_output("mid_rst_ram_en", bus.ram_en, 1'b0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    step();
    check_output("post_rst_tie_m0", mdl_pending, 0);
    step();
    check_output("post_rst_m0_ready", obs_m0_ready, 1'b1);

    // Quiet bus: nothing may be issued or acknowledged.
    do_reset();
    for (int i = 0; i < 10; i++) step();

    // Random traffic over a small address window to exercise read-after-write.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.m0_valid = ($urandom_range(0, 9) < 7);
      bus.m0_addr  = AW'($urandom_range(0, 7));
      bus.m0_wdata = $urandom;
      bus.m0_wstrb = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
      bus.m1_valid = ($urandom_range(0, 9) < 6);
      bus.m1_addr  = AW'($urandom_range(0, 7));
      bus.m1_wdata = $urandom;
      bus.m1_wstrb = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
      bus.m1_lock  = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
